// File: rtl/tile_dim_credit_router.sv
// One-dimension mesh router stage: credit-flow-controlled link queues, inject stage, eject arbitration.
// Optional macro ROUTER_RR_FAIR_EN: round-robin transit/inject sharing per output instead of strict transit priority.
module tile_dim_credit_router #(
  parameter int TILE_X  = 0,
  parameter int TILE_Y  = 0,
  parameter int DIM     = 0,
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 528,
  parameter int ADDR_W  = 33,
  parameter int SZ_W    = 12,
  parameter int COORD_W = 5,
  localparam int FLIT_W = DATA_W + SZ_W + ADDR_W + 2 * COORD_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          inj_valid,
  output logic                          inj_ready,
  input  logic [FLIT_W-1:0]             inj_flit,
  input  logic [1:0]                    lnk_in_vld,
  input  logic [2*FLIT_W-1:0]           lnk_in_flit,
  output logic [1:0]                    lnk_credit_out,
  output logic [1:0]                    lnk_out_vld,
  output logic [2*FLIT_W-1:0]           lnk_out_flit,
  input  logic [1:0]                    lnk_credit_in,
  output logic                          ej_valid,
  input  logic                          ej_ready,
  output logic [DATA_W-1:0]             ej_data,
  output logic [2*COORD_W+ADDR_W-1:0]   ej_addr,
  output logic [SZ_W-1:0]               ej_size,
  output logic                          err_ovf
);
  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_W   = AW + 1;
  localparam int BODY_W  = DATA_W + SZ_W + ADDR_W;
  localparam int KEY_LSB = (DIM != 0) ? BODY_W + COORD_W : BODY_W;
  localparam logic [COORD_W-1:0] TX_C = COORD_W'(TILE_X);
  localparam logic [COORD_W-1:0] TY_C = COORD_W'(TILE_Y);
  localparam logic [COORD_W-1:0] T_C  = (DIM != 0) ? TY_C : TX_C;
  localparam logic [1:0] RT_EJ = 2'd0, RT_O0 = 2'd1, RT_O1 = 2'd2;

  typedef enum logic [1:0] {SRC_H0 = 2'd0, SRC_H1 = 2'd1, SRC_INJ = 2'd2, SRC_NONE = 2'd3} ej_src_e;

  function automatic logic [1:0] route_f(input logic [COORD_W-1:0] key);
    if (key > T_C)      route_f = RT_O1;
    else if (key < T_C) route_f = RT_O0;
    else                route_f = RT_EJ;
  endfunction

  logic [FLIT_W-1:0] q_mem_r [2][DEPTH];
  logic [CNT_W-1:0]  q_wr_r [2];
  logic [CNT_W-1:0]  q_rd_r [2];
  logic [CNT_W-1:0]  cred_r [2];
  logic              inj_vld_r;
  logic [FLIT_W-1:0] inj_flit_r;
  logic [1:0]        out_vld_r;
  logic [FLIT_W-1:0] out_flit_r [2];
  logic              err_ovf_r;
  logic              ej_last_r;
  logic              ej_hold_r;
  ej_src_e           ej_hold_src_r;
`ifdef ROUTER_RR_FAIR_EN
  logic [1:0]        fav_inj_r;
`endif

  logic [1:0]        head_vld_s, head_ej_s, full_s, pop_s, push_s;
  logic [1:0]        t_req_s, i_req_s, grant_t_s, grant_i_s, send_s;
  logic [FLIT_W-1:0] head_flit_s [2];
  logic [FLIT_W-1:0] send_flit_s [2];
  logic [1:0]        inj_rt_s;
  ej_src_e           ej_src_s;
  logic              ej_vld_s, ej_fire_s, inj_drain_s;
  logic [BODY_W-1:0] ej_body_s;

  // Queue head, occupancy and routing of each head and of the inject stage
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      head_vld_s[i]  = (q_wr_r[i] != q_rd_r[i]);
      full_s[i]      = ((q_wr_r[i] - q_rd_r[i]) == CNT_W'(DEPTH));
      head_flit_s[i] = q_mem_r[i][q_rd_r[i][AW-1:0]];
      head_ej_s[i]   = head_vld_s[i] && (route_f(head_flit_s[i][KEY_LSB +: COORD_W]) == RT_EJ);
    end
    inj_rt_s = route_f(inj_flit_r[KEY_LSB +: COORD_W]);
  end

  // Per-output arbitration: queue 0 travels up to output 1, queue 1 travels down to output 0
  always_comb begin
    for (int o = 0; o < 2; o++) begin
      t_req_s[o] = head_vld_s[1-o] && !head_ej_s[1-o];
      i_req_s[o] = inj_vld_r && (inj_rt_s == ((o == 0) ? RT_O0 : RT_O1));
      if (cred_r[o] != '0) begin
`ifdef ROUTER_RR_FAIR_EN
        if (t_req_s[o] && i_req_s[o]) begin
          grant_i_s[o] = fav_inj_r[o];
          grant_t_s[o] = !fav_inj_r[o];
        end else begin
          grant_i_s[o] = i_req_s[o];
          grant_t_s[o] = t_req_s[o];
        end
`else
        grant_t_s[o] = t_req_s[o];
        grant_i_s[o] = i_req_s[o] && !t_req_s[o];
`endif
      end else begin
        grant_t_s[o] = 1'b0;
        grant_i_s[o] = 1'b0;
      end
      send_s[o]      = grant_t_s[o] || grant_i_s[o];
      send_flit_s[o] = grant_t_s[o] ? head_flit_s[1-o] : inj_flit_r;
    end
  end

  // Eject selection (held while the sink stalls), pops, pushes and inject drain
  always_comb begin
    if (ej_hold_r)                        ej_src_s = ej_hold_src_r;
    else if (head_ej_s[0] && head_ej_s[1]) ej_src_s = ej_last_r ? SRC_H0 : SRC_H1;
    else if (head_ej_s[0])                ej_src_s = SRC_H0;
    else if (head_ej_s[1])                ej_src_s = SRC_H1;
    else if (inj_vld_r && inj_rt_s == RT_EJ) ej_src_s = SRC_INJ;
    else                                  ej_src_s = SRC_NONE;
    case (ej_src_s)
      SRC_H0:  ej_body_s = head_flit_s[0][BODY_W-1:0];
      SRC_H1:  ej_body_s = head_flit_s[1][BODY_W-1:0];
      SRC_INJ: ej_body_s = inj_flit_r[BODY_W-1:0];
      default: ej_body_s = '0;
    endcase
    ej_vld_s    = (ej_src_s != SRC_NONE);
    ej_fire_s   = ej_vld_s && ej_ready;
    pop_s[0]    = grant_t_s[1] || (ej_fire_s && ej_src_s == SRC_H0);
    pop_s[1]    = grant_t_s[0] || (ej_fire_s && ej_src_s == SRC_H1);
    inj_drain_s = (|grant_i_s) || (ej_fire_s && ej_src_s == SRC_INJ);
    for (int i = 0; i < 2; i++) begin
      push_s[i] = lnk_in_vld[i] && (!full_s[i] || pop_s[i]);
    end
  end

  // Queue storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push_s[i]) q_mem_r[i][q_wr_r[i][AW-1:0]] <= lnk_in_flit[i*FLIT_W +: FLIT_W];
    end
  end

  // Control state: pointers, credits, inject stage, link output registers, eject history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        q_wr_r[i]     <= '0;
        q_rd_r[i]     <= '0;
        cred_r[i]     <= CNT_W'(DEPTH);
        out_flit_r[i] <= '0;
      end
      inj_vld_r     <= 1'b0;
      inj_flit_r    <= '0;
      out_vld_r     <= 2'b00;
      err_ovf_r     <= 1'b0;
      ej_last_r     <= 1'b0;
      ej_hold_r     <= 1'b0;
      ej_hold_src_r <= SRC_NONE;
`ifdef ROUTER_RR_FAIR_EN
      fav_inj_r     <= 2'b00;
`endif
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push_s[i]) q_wr_r[i] <= q_wr_r[i] + CNT_W'(1);
        if (pop_s[i])  q_rd_r[i] <= q_rd_r[i] + CNT_W'(1);
        case ({send_s[i], lnk_credit_in[i]})
          2'b10:   cred_r[i] <= cred_r[i] - CNT_W'(1);
          2'b01:   if (cred_r[i] != CNT_W'(DEPTH)) cred_r[i] <= cred_r[i] + CNT_W'(1);
          default: cred_r[i] <= cred_r[i];
        endcase
        if (send_s[i]) out_flit_r[i] <= send_flit_s[i];
`ifdef ROUTER_RR_FAIR_EN
        if (t_req_s[i] && i_req_s[i] && send_s[i]) fav_inj_r[i] <= grant_t_s[i];
`endif
      end
      if (inj_valid && inj_ready) begin
        inj_vld_r  <= 1'b1;
        inj_flit_r <= inj_flit;
      end else if (inj_drain_s) begin
        inj_vld_r  <= 1'b0;
      end
      out_vld_r     <= send_s;
      err_ovf_r     <= err_ovf_r || (|(lnk_in_vld & full_s & ~pop_s));
      if (ej_fire_s && ej_src_s == SRC_H0) ej_last_r <= 1'b0;
      else if (ej_fire_s && ej_src_s == SRC_H1) ej_last_r <= 1'b1;
      ej_hold_r     <= ej_vld_s && !ej_ready;
      ej_hold_src_r <= ej_src_s;
    end
  end

  assign inj_ready      = !inj_vld_r || inj_drain_s;
  assign lnk_credit_out = pop_s;
  assign lnk_out_vld    = out_vld_r;
  assign lnk_out_flit   = {out_flit_r[1], out_flit_r[0]};
  assign ej_valid       = ej_vld_s;
  assign ej_data        = ej_body_s[DATA_W-1:0];
  assign ej_size        = ej_body_s[DATA_W +: SZ_W];
  assign ej_addr        = {TY_C, TX_C, ej_body_s[DATA_W+SZ_W +: ADDR_W]};
  assign err_ovf        = err_ovf_r;
endmodule

// File: tb/tb_tile_dim_credit_router.sv
// Bench for tile_dim_credit_router (TILE_X=3, TILE_Y=2, DIM=0, DEPTH=8): routing table,
// credit exhaustion, transit/inject contention, eject round-robin, overflow and async reset.
module tb_tile_dim_credit_router;
  localparam int TX = 3, TY = 2, DEPTH = 8, DW = 16, AW = 8, SW = 4, CW = 5;
  localparam int FW = DW + SW + AW + 2 * CW;
  typedef logic [FW-1:0] flit_t;
  typedef struct { int src; logic [4:0] tx; logic [4:0] ty; int port; int lat; } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic inj_valid = 1'b0, inj_ready;
  flit_t inj_flit = '0;
  logic [1:0] lnk_in_vld = 2'b00, lnk_credit_out, lnk_out_vld, lnk_credit_in = 2'b00;
  logic [2*FW-1:0] lnk_in_flit = '0, lnk_out_flit;
  logic ej_valid, ej_ready = 1'b1, err_ovf;
  logic [DW-1:0] ej_data;
  logic [2*CW+AW-1:0] ej_addr;
  logic [SW-1:0] ej_size;

  tile_dim_credit_router #(.TILE_X(TX), .TILE_Y(TY), .DIM(0), .DEPTH(DEPTH), .DATA_W(DW),
                           .ADDR_W(AW), .SZ_W(SW), .COORD_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_flit(inj_flit),
    .lnk_in_vld(lnk_in_vld), .lnk_in_flit(lnk_in_flit), .lnk_credit_out(lnk_credit_out),
    .lnk_out_vld(lnk_out_vld), .lnk_out_flit(lnk_out_flit), .lnk_credit_in(lnk_credit_in),
    .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_data(ej_data), .ej_addr(ej_addr),
    .ej_size(ej_size), .err_ovf(err_ovf));

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  bit mon_en = 1'b0;
  flit_t exp_q0[$], exp_q1[$], exp_ej[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic flit_t mk(input logic [4:0] ty, input logic [4:0] tx, input logic [7:0] addr,
                               input logic [3:0] sz, input logic [15:0] data);
    return {ty, tx, addr, sz, data};
  endfunction

  function automatic logic [63:0] ej_exp(input flit_t f);
    return 64'({5'(TY), 5'(TX), f[DW+SW +: AW], f[DW +: SW], f[DW-1:0]});
  endfunction

  // Scoreboard: every link send and eject handshake is matched against the expected queues
  always @(negedge clk) begin
    #2;
    if (mon_en && rst_n) begin
      if (lnk_out_vld[0]) begin
        chk("out0_expected", 64'(exp_q0.size() != 0), 64'd1);
        if (exp_q0.size() != 0) chk("out0_flit", 64'(lnk_out_flit[FW-1:0]), 64'(exp_q0.pop_front()));
      end
      if (lnk_out_vld[1]) begin
        chk("out1_expected", 64'(exp_q1.size() != 0), 64'd1);
        if (exp_q1.size() != 0) chk("out1_flit", 64'(lnk_out_flit[2*FW-1:FW]), 64'(exp_q1.pop_front()));
      end
      if (ej_valid && ej_ready) begin
        chk("ej_expected", 64'(exp_ej.size() != 0), 64'd1);
        if (exp_ej.size() != 0) chk("ej_fields", 64'({ej_addr, ej_size, ej_data}), ej_exp(exp_ej.pop_front()));
      end
    end
  end

  // 9 back-to-back link-0 arrivals headed up; returns how many reached output 1
  task automatic burst(output int sent);
    flit_t bf;
    sent = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      if (lnk_out_vld[1]) sent++;
      bf = mk(5'd0, 5'd5, 8'(i), 4'd0, 16'(16'h3000 + i));
      lnk_in_vld = 2'b01; lnk_in_flit[FW-1:0] = bf;
      if (mon_en) exp_q1.push_back(bf);
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); #1;
      lnk_in_vld = 2'b00;
      if (lnk_out_vld[1]) sent++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[10];
  flit_t f;
  int got, sent, s0, s1, inj_cnt, ejc;
  logic [1:0] cmask;

  initial begin
    vecs[0] = '{0, 5'd5,  5'd0, 1, 2};
    vecs[1] = '{0, 5'd1,  5'd0, 0, 2};
    vecs[2] = '{1, 5'd5,  5'd1, 1, 2};
    vecs[3] = '{2, 5'd1,  5'd4, 0, 2};
    vecs[4] = '{1, 5'd0,  5'd0, 1, 2};
    vecs[5] = '{1, 5'd3,  5'd6, 2, 1};
    vecs[6] = '{2, 5'd3,  5'd9, 2, 1};
    vecs[7] = '{0, 5'd3,  5'd7, 2, 1};
    vecs[8] = '{0, 5'd31, 5'd0, 1, 2};
    vecs[9] = '{0, 5'd0,  5'd3, 0, 2};

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_inj_ready", 64'(inj_ready), 64'd1);
    chk("rst_out_vld", 64'(lnk_out_vld), 64'd0);
    chk("rst_credit_out", 64'(lnk_credit_out), 64'd0);
    chk("rst_ej_valid", 64'(ej_valid), 64'd0);
    chk("rst_err_ovf", 64'(err_ovf), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    mon_en = 1'b1;

    // routing table: destination port, latency and credit pulse per vector
    for (int v = 0; v < 10; v++) begin
      f = mk(vecs[v].ty, vecs[v].tx, 8'(3 * v + 1), 4'(v), 16'(16'h1000 + v));
      @(negedge clk);
      case (vecs[v].src)
        0: begin inj_valid = 1'b1; inj_flit = f; end
        1: begin lnk_in_vld = 2'b01; lnk_in_flit[FW-1:0] = f; end
        default: begin lnk_in_vld = 2'b10; lnk_in_flit[2*FW-1:FW] = f; end
      endcase
      case (vecs[v].port)
        0: exp_q0.push_back(f);
        1: exp_q1.push_back(f);
        default: exp_ej.push_back(f);
      endcase
      cmask = (vecs[v].src == 0) ? 2'b00 : 2'(1 << (vecs[v].src - 1));
      got = 0;
      for (int n = 1; n <= 4; n++) begin
        @(negedge clk); inj_valid = 1'b0; lnk_in_vld = 2'b00; #1;
        if (n == 1) chk($sformatf("vec%0d_credit_out", v), 64'(lnk_credit_out), 64'(cmask));
        if (got == 0 && ((vecs[v].port == 2) ? ej_valid : lnk_out_vld[vecs[v].port])) got = n;
      end
      chk($sformatf("vec%0d_latency", v), 64'(got), 64'(vecs[v].lat));
      if (vecs[v].port < 2) begin
        @(negedge clk); lnk_credit_in[vecs[v].port] = 1'b1;
        @(negedge clk); lnk_credit_in = 2'b00;
      end
    end
    #3;
    chk("table_drained", 64'(exp_q0.size() + exp_q1.size() + exp_ej.size()), 64'd0);

    // credit exhaustion: surplus credit pulses must not lift the counter above DEPTH
    @(negedge clk); lnk_credit_in = 2'b10;
    repeat (2) @(negedge clk);
    lnk_credit_in = 2'b00;
    burst(sent);
    chk("credit_limit_sent", 64'(sent), 64'd8);
    @(negedge clk); lnk_credit_in = 2'b10; #1;
    chk("ninth_held", 64'(lnk_out_vld[1]), 64'd0);
    @(negedge clk); lnk_credit_in = 2'b00; #1;
    chk("ninth_not_yet", 64'(lnk_out_vld[1]), 64'd0);
    @(negedge clk); #1;
    chk("ninth_sent", 64'(lnk_out_vld[1]), 64'd1);
    lnk_credit_in = 2'b10;
    repeat (9) @(negedge clk);
    lnk_credit_in = 2'b00; #3;
    chk("credit_drained", 64'(exp_q1.size()), 64'd0);

    // transit vs inject contention on output 1, output 0 busy in parallel
    mon_en = 1'b0; lnk_credit_in = 2'b11;
    s0 = 0; s1 = 0; inj_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (i >= 3) begin
        if (lnk_out_vld[0]) s0++;
        if (lnk_out_vld[1]) begin
          s1++;
          if (lnk_out_flit[FW+DW-1:FW] == 16'hBEEF) inj_cnt++;
        end
      end
      lnk_in_vld  = 2'b11;
      lnk_in_flit = {mk(5'd0, 5'd1, 8'(i), 4'd2, 16'(16'h2200 + i)), mk(5'd0, 5'd5, 8'(i), 4'd1, 16'(16'h2100 + i))};
      inj_valid   = 1'b1;
      inj_flit    = mk(5'd0, 5'd5, 8'h55, 4'h5, 16'hBEEF);
    end
    chk("contend_out0_sends", 64'(s0), 64'd9);
    chk("contend_out1_sends", 64'(s1), 64'd9);
`ifdef ROUTER_RR_FAIR_EN
    chk("inject_fair_share", 64'(inj_cnt >= 4), 64'd1);
`else
    chk("inject_starved", 64'(inj_cnt), 64'd0);
`endif
    @(negedge clk); lnk_in_vld = 2'b00; inj_valid = 1'b0;
    repeat (20) @(negedge clk);
    lnk_credit_in = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    chk("contend_drained_inj", 64'(inj_ready), 64'd1);
    chk("contend_drained_out", 64'(lnk_out_vld), 64'd0);
    chk("contend_no_ovf", 64'(err_ovf), 64'd0);

    // eject round-robin with an initial stall; last head grant was link 1, so head 0 goes first
    mon_en = 1'b1; ej_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lnk_in_vld  = 2'b11;
      lnk_in_flit = {mk(5'd0, 5'd3, 8'(32 + i), 4'd2, 16'(16'h0200 + i)), mk(5'd0, 5'd3, 8'(16 + i), 4'd1, 16'(16'h0100 + i))};
    end
    @(negedge clk); lnk_in_vld = 2'b00;
    for (int h = 0; h < 3; h++) begin
      #1;
      chk("stall_ej_valid", 64'(ej_valid), 64'd1);
      chk("stall_ej_data", 64'(ej_data), 64'h0100);
      chk("stall_no_pop", 64'(lnk_credit_out), 64'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      exp_ej.push_back(mk(5'd0, 5'd3, 8'(16 + i), 4'd1, 16'(16'h0100 + i)));
      exp_ej.push_back(mk(5'd0, 5'd3, 8'(32 + i), 4'd2, 16'(16'h0200 + i)));
    end
    ej_ready = 1'b1;
    repeat (8) @(negedge clk);
    #3;
    chk("rr_all_ejected", 64'(exp_ej.size()), 64'd0);
    chk("rr_idle", 64'(ej_valid), 64'd0);

    // overflow: 8 fill queue 0, 9th is dropped and flagged
    mon_en = 1'b0; ej_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); lnk_in_vld = 2'b01; lnk_in_flit[FW-1:0] = mk(5'd0, 5'd3, 8'(i), 4'd0, 16'(16'h4000 + i));
    end
    @(negedge clk); lnk_in_vld = 2'b00; #1;
    chk("ovf_before", 64'(err_ovf), 64'd0);
    lnk_in_vld = 2'b01; lnk_in_flit[FW-1:0] = mk(5'd0, 5'd3, 8'hFF, 4'd0, 16'h4999);
    @(negedge clk); lnk_in_vld = 2'b00; #1;
    chk("ovf_set", 64'(err_ovf), 64'd1);
    ej_ready = 1'b1; ejc = 0;
    for (int i = 0; i < 12; i++) begin
      #1; if (ej_valid && ej_ready) ejc++;
      @(negedge clk);
    end
    chk("ovf_queue_count", 64'(ejc), 64'd8);
    chk("ovf_sticky", 64'(err_ovf), 64'd1);

    // asynchronous reset in the middle of traffic
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inj_valid = 1'b1; inj_flit = mk(5'd0, 5'd5, 8'(i), 4'd3, 16'(16'h5000 + i));
      lnk_in_vld = 2'b01; lnk_in_flit[FW-1:0] = mk(5'd0, 5'd5, 8'(i), 4'd4, 16'(16'h6000 + i));
    end
    @(negedge clk); #1;
    chk("pre_reset_traffic", 64'(lnk_out_vld[1]), 64'd1);
    #2 rst_n = 1'b0; #1;
    chk("arst_out_vld", 64'(lnk_out_vld), 64'd0);
    chk("arst_ej_valid", 64'(ej_valid), 64'd0);
    chk("arst_err_ovf", 64'(err_ovf), 64'd0);
    chk("arst_inj_ready", 64'(inj_ready), 64'd1);
    chk("arst_credit_out", 64'(lnk_credit_out), 64'd0);
    @(negedge clk); inj_valid = 1'b0; lnk_in_vld = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    burst(sent);
    chk("credits_restored", 64'(sent), 64'd8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
